// File: rtl/raster_pkg.sv
// Shared constants and types for the edge rasterizer and the fill block that
// consumes its bitmap.
package raster_pkg;

  localparam int COORD_BITS = 6;
  localparam int GRID_W     = 2 ** COORD_BITS;
  localparam int BUF_BITS   = GRID_W * GRID_W;

  typedef logic [COORD_BITS-1:0] coord_t;
  typedef logic signed [7:0]     err_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? coord_t'(a - b) : coord_t'(b - a);
  endfunction

endpackage

// File: rtl/line_rasterizer_if.sv
// Command/status bundle between the segment source (master) and the rasterizer
// (slave); line_buffer feeds the fill block directly.
interface line_rasterizer_if;
  import raster_pkg::*;

  logic                clear;
  logic                draw_en;
  coord_t              x0;
  coord_t              y0;
  coord_t              x1;
  coord_t              y1;
  logic                busy;
  logic                done;
  logic [BUF_BITS-1:0] line_buffer;

  modport master (
    output clear, draw_en, x0, y0, x1, y1,
    input  busy, done, line_buffer
  );

  modport slave (
    input  clear, draw_en, x0, y0, x1, y1,
    output busy, done, line_buffer
  );

endinterface

// File: rtl/bresenham_step.sv
// One Bresenham iteration: advances the current point and error term, and flags
// when the current point is the segment end.
module bresenham_step
  import raster_pkg::*;
(
  input  coord_t cx_i,
  input  coord_t cy_i,
  input  coord_t ex_i,
  input  coord_t ey_i,
  input  err_t   err_i,
  input  err_t   dx_i,
  input  err_t   dy_i,
  input  logic   sx_neg_i,
  input  logic   sy_neg_i,
  output coord_t cx_o,
  output coord_t cy_o,
  output err_t   err_o,
  output logic   last_o
);

  logic signed [8:0] e2;
  logic signed [8:0] dx_w;
  logic signed [8:0] dy_w;
  logic              step_x;
  logic              step_y;

  always_comb begin
    // NOTE: every output of this block is given a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    e2     = {err_i, 1'b0};
    dx_w   = {dx_i[7], dx_i};
    dy_w   = {dy_i[7], dy_i};
    step_x = (e2 >= dy_w);
    step_y = (e2 <= dx_w);
    cx_o   = cx_i;
    cy_o   = cy_i;
    err_o  = err_i;
    // Both tests use the same e2; the error picks up the sum of both updates.
    if (step_x) begin
      err_o = err_o + dy_i;
      cx_o  = sx_neg_i ? cx_i - coord_t'(1) : cx_i + coord_t'(1);
    end
    if (step_y) begin
      err_o = err_o + dx_i;
      cy_o  = sy_neg_i ? cy_i - coord_t'(1) : cy_i + coord_t'(1);
    end
  end

  assign last_o = (cx_i == ex_i) && (cy_i == ey_i);

endmodule

// File: rtl/line_rasterizer.sv
// Draws one line segment per draw_en into a 64x64 edge bitmap (bit y*64+x),
// accumulating segments until the bitmap is cleared.
module line_rasterizer
  import raster_pkg::*;
(
  input logic               clk,
  input logic               n_rst,
  line_rasterizer_if.slave  bus
);

  state_t              state_q;
  coord_t              cx_q, cy_q, ex_q, ey_q;
  err_t                dx_q, dy_q, err_q;
  logic                sx_neg_q, sy_neg_q;
  logic                busy_q, done_q;
  logic [BUF_BITS-1:0] buf_q;

  coord_t              cx_d, cy_d;
  err_t                err_d;
  logic                last;

  coord_t              adx, ady;
  err_t                dx_init, dy_init, err_init;
  logic [2*COORD_BITS-1:0] pix_idx;

  assign adx      = abs_diff(bus.x1, bus.x0);
  assign ady      = abs_diff(bus.y1, bus.y0);
  assign dx_init  = err_t'({2'b00, adx});
  assign dy_init  = err_t'(8'd0 - {2'b00, ady});
  assign err_init = dx_init + dy_init;
  assign pix_idx  = {cy_q, cx_q};

  bresenham_step u_step (
    .cx_i     (cx_q),
    .cy_i     (cy_q),
    .ex_i     (ex_q),
    .ey_i     (ey_q),
    .err_i    (err_q),
    .dx_i     (dx_q),
    .dy_i     (dy_q),
    .sx_neg_i (sx_neg_q),
    .sy_neg_i (sy_neg_q),
    .cx_o     (cx_d),
    .cy_o     (cy_d),
    .err_o    (err_d),
    .last_o   (last)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!n_rst) begin
      state_q  <= IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      ex_q     <= '0;
      ey_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      // NOTE: the bitmap is a flop array read in parallel by the fill block,
      // not a RAM, so it takes the reset like any other register.
      buf_q    <= '0;
    end else if (bus.clear) begin
      buf_q   <= '0;
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.draw_en) begin
            cx_q     <= bus.x0;
            cy_q     <= bus.y0;
            ex_q     <= bus.x1;
            ey_q     <= bus.y1;
            dx_q     <= dx_init;
            dy_q     <= dy_init;
            err_q    <= err_init;
            sx_neg_q <= (bus.x1 < bus.x0);
            sy_neg_q <= (bus.y1 < bus.y0);
            busy_q   <= 1'b1;
            state_q  <= DRAW;
          end
        end
        DRAW: begin
          buf_q[pix_idx] <= 1'b1;
          if (last) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cx_q  <= cx_d;
            cy_q  <= cy_d;
            err_q <= err_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.line_buffer = buf_q;

endmodule
